prog_loader: RTL and testbench
==============================

# prog_loader

Serial program loader that writes a RISC-V program image into instruction memory before the single-cycle core runs. It accepts a byte stream over a valid/ready handshake, carrying a length header, payload words and a checksum. It assembles little-endian 32-bit instruction words and issues one write per word to the instruction-memory write port. It holds the core in reset until a complete, checksum-correct image has been loaded.

## Interface
Parameters:
- ADDR_W, 10: instruction-memory word-address width. Capacity is 2^ADDR_W words.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse that begins a load; honoured only in IDLE, DONE and ERR.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address of the current write.
- imem_wdata  out  32  assembled instruction word.
- cpu_reset  out  1  holds the core in reset while high.
- busy  out  1  a load is in progress.
- done  out  1  last load completed with a good checksum (level).
- err  out  1  last load failed (level).

## Operation
- Stream format, in order:
  - LEN_LO, LEN_HI: 16-bit word count N, little-endian.
  - 4·N payload bytes: per word, byte0 → wdata[7:0] through byte3 → wdata[31:24].
  - One CSUM byte: sum of all payload bytes mod 256. The length bytes are excluded.
- A byte transfers only on a cycle where byte_valid && byte_ready.
- States and transitions:
  - IDLE → LEN_LO on start.
  - LEN_LO → LEN_HI on transfer.
  - LEN_HI on transfer:
    - → ERR if N > 2^ADDR_W.
    - → CSUM if N = 0.
    - → DATA otherwise.
  - DATA: collects 4 bytes with a 2-bit byte counter, then → WRITE.
  - WRITE: lasts one cycle, with imem_we=1, imem_addr=word index, imem_wdata=assembled word.
    - Then the word index increments, and the state goes → DATA if words remain, else → CSUM.
  - CSUM on transfer: → DONE if the byte equals the running sum, else → ERR.
  - DONE and ERR are terminal until the next start, which re-enters LEN_LO.
- On any start that is honoured, the loader clears:
  - the running sum,
  - the word index,
  - the byte counter,
  - done and err.
- byte_ready=1 only in LEN_LO, LEN_HI, DATA and CSUM. It is 0 in IDLE, WRITE, DONE and ERR.
- start while busy is ignored.
- Word index width is ADDR_W+1 so that N = 2^ADDR_W terminates correctly. imem_addr is its low ADDR_W bits.
- Running sum is 8 bits and wraps silently.
- cpu_reset:
  - 1 from reset and through any load.
  - Cleared only on entry to DONE.
  - Set again on an honoured start.
  - Stays 1 in ERR.
- busy=1 in LEN_LO through CSUM inclusive.

## Timing
- Reset values:
  - state IDLE
  - byte_ready 0, imem_we 0, imem_addr 0, imem_wdata 0
  - cpu_reset 1, busy 0, done 0, err 0
- All outputs are registered or decoded from the state register. There is no combinational path from byte_valid to byte_ready.
- Per word: at least 4 accepted bytes plus 1 WRITE cycle. The minimum load is 2 + 5·N + 1 cycles after the start cycle.
- done, err and the cpu_reset deassertion become visible the cycle after the accepting CSUM transfer.
- Reset asserted mid-load aborts immediately to the reset values. No partial write completes after reset asserts. Memory already written keeps its contents.
- Stalls (byte_valid=0) of any length in any receiving state hold all state.

## Structure
- Shared package holds:
  - the state encoding as an 8-value enum (3 bits),
  - byte-position constants,
  - the header size (2).
- One sub-module is natural: byte_packer, containing the 2-bit counter and the 32-bit little-endian shift register. It signals word_full after byte 3.
- The FSM, word index, checksum and output logic live in prog_loader.

## Test plan
- Two words, no stalls. Stream 02 00 93 00 50 00 13 81 10 00 87 →
  - imem writes 0x00500093 @0 and 0x00108113 @1,
  - then done=1, cpu_reset=0, err=0.
- Same stream with a bad checksum (CSUM 88) → both writes still occur; err=1, done=0, cpu_reset stays 1.
- N=0. Stream 00 00 00 → no imem_we pulse; done=1.
- N = 2^ADDR_W + 1, with ADDR_W=10 so N = 0x0401. Stream 01 04 → err=1 after LEN_HI; byte_ready=0; no writes.
- Random byte_valid gaps plus start pulses mid-load → identical writes and done as the no-stall case; start pulses are ignored.
- reset asserted after the 6th payload byte, then released; start, then a full valid stream → outputs are at reset values during reset, and the reload completes normally with writes from address 0.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared state encoding and stream constants for prog_loader
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_CSUM   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } state_t;

  localparam logic [1:0] BYTE_POS0 = 2'd0;
  localparam logic [1:0] BYTE_POS1 = 2'd1;
  localparam logic [1:0] BYTE_POS2 = 2'd2;
  localparam logic [1:0] BYTE_POS3 = 2'd3;

  localparam int HDR_BYTES = 2;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// rtl/prog_loader_byte_packer.sv - collects four stream bytes into a little-endian word
module prog_loader_byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0] cnt;

  // Shifting in from the top leaves byte0 in [7:0] after the fourth byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= BYTE_POS0;
      word <= '0;
    end else if (clear) begin
      cnt  <= BYTE_POS0;
      word <= '0;
    end else if (shift) begin
      cnt  <= cnt + 2'd1;
      word <= {byte_data, word[31:8]};
    end
  end

  assign word_full = shift && (cnt == BYTE_POS3);

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader writing instruction memory and gating core reset
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t          state, state_nx;
  logic [15:0]     len;
  logic [ADDR_W:0] widx;
  logic [ADDR_W:0] widx_inc;
  logic [7:0]      sum;
  logic [31:0]     word;
  logic            word_full;
  logic            xfer;
  logic            go;
  logic [15:0]     hdr_len;
  logic            len_too_big;
  logic            more_words;

  assign byte_ready  = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                       (state == ST_DATA)   || (state == ST_CSUM);
  assign busy        = byte_ready || (state == ST_WRITE);
  assign xfer        = byte_valid && byte_ready;
  assign go          = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
  assign hdr_len     = {byte_data, len[7:0]};
  assign len_too_big = 32'(hdr_len) > (32'd1 << ADDR_W);
  // Index is one bit wider than the address so a full-memory image still terminates.
  assign widx_inc    = widx + 1'b1;
  assign more_words  = 32'(widx_inc) < 32'(len);

  assign imem_we    = (state == ST_WRITE);
  assign imem_addr  = widx[ADDR_W-1:0];
  assign imem_wdata = imem_we ? word : '0;

  prog_loader_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (go),
    .shift     ((state == ST_DATA) && xfer),
    .byte_data (byte_data),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) state_nx = ST_LEN_LO;
      ST_LEN_LO: if (xfer) state_nx = ST_LEN_HI;
      ST_LEN_HI: begin
        if (xfer) begin
          if (len_too_big)       state_nx = ST_ERR;
          else if (hdr_len == 0) state_nx = ST_CSUM;
          else                   state_nx = ST_DATA;
        end
      end
      ST_DATA:  if (word_full) state_nx = ST_WRITE;
      ST_WRITE: state_nx = more_words ? ST_DATA : ST_CSUM;
      ST_CSUM:  if (xfer) state_nx = (byte_data == sum) ? ST_DONE : ST_ERR;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len       <= '0;
      widx      <= '0;
      sum       <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else if (go) begin
      widx      <= '0;
      sum       <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      if ((state == ST_LEN_LO) && xfer) len[7:0]  <= byte_data;
      if ((state == ST_LEN_HI) && xfer) len[15:8] <= byte_data;
      if ((state == ST_LEN_HI) && xfer && len_too_big) err <= 1'b1;
      if ((state == ST_DATA) && xfer) sum <= sum + byte_data;
      if (state == ST_WRITE) widx <= widx_inc;
      if ((state == ST_CSUM) && xfer) begin
        if (byte_data == sum) begin
          done      <= 1'b1;
          cpu_reset <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              err;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [7:0]  stream[$];

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && imem_we) begin
      wa.push_back(32'(imem_addr));
      wd.push_back(imem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 40) begin
      tick();
      n++;
    end
    if (!byte_ready) chk("ready_timeout", 32'(byte_ready), 32'd1);
    tick();
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  task automatic run_stream(input bit stall);
    foreach (stream[i]) begin
      if (stall) begin
        int g;
        g = $urandom_range(0, 3);
        for (int k = 0; k < g; k++) begin
          start = ($urandom_range(0, 1) == 1);
          tick();
          start = 1'b0;
        end
      end
      send(stream[i]);
    end
  endtask

  task automatic chk_two_writes(input string tag);
    chk({tag, "_nwr"}, 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      chk({tag, "_a0"}, wa[0], 32'd0);
      chk({tag, "_d0"}, wd[0], 32'h0050_0093);
      chk({tag, "_a1"}, wa[1], 32'd1);
      chk({tag, "_d1"}, wd[1], 32'h0010_8113);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_we"},    32'(imem_we),    32'd0);
    chk({tag, "_addr"},  32'(imem_addr),  32'd0);
    chk({tag, "_wdata"}, imem_wdata,      32'd0);
    chk({tag, "_cpurst"},32'(cpu_reset),  32'd1);
    chk({tag, "_busy"},  32'(busy),       32'd0);
    chk({tag, "_done"},  32'(done),       32'd0);
    chk({tag, "_err"},   32'(err),        32'd0);
  endtask

  initial begin
    tick();
    tick();
    chk_reset_values("rst");
    reset = 1'b0;
    tick();
    chk_reset_values("idle");

    // Two words, no stalls.
    wa.delete(); wd.delete();
    stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h81, 8'h10, 8'h00, 8'h87};
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready", 32'(byte_ready), 32'd1);
    run_stream(1'b0);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_cpurst", 32'(cpu_reset), 32'd0);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk_two_writes("t1");

    // Bad checksum; start from DONE must clear done and reassert cpu_reset.
    wa.delete(); wd.delete();
    stream[10] = 8'h88;
    pulse_start();
    chk("t2_done_clr", 32'(done), 32'd0);
    chk("t2_cpurst_set", 32'(cpu_reset), 32'd1);
    run_stream(1'b0);
    chk("t2_err", 32'(err), 32'd1);
    chk("t2_done", 32'(done), 32'd0);
    chk("t2_cpurst", 32'(cpu_reset), 32'd1);
    chk("t2_ready", 32'(byte_ready), 32'd0);
    chk_two_writes("t2");

    // Empty image.
    wa.delete(); wd.delete();
    stream = '{8'h00, 8'h00, 8'h00};
    pulse_start();
    chk("t3_err_clr", 32'(err), 32'd0);
    run_stream(1'b0);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_err", 32'(err), 32'd0);
    chk("t3_nwr", 32'(wa.size()), 32'd0);

    // Image one word larger than memory.
    wa.delete(); wd.delete();
    stream = '{8'h01, 8'h04};
    pulse_start();
    run_stream(1'b0);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_done", 32'(done), 32'd0);
    chk("t4_ready", 32'(byte_ready), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    tick();
    tick();
    chk("t4_nwr", 32'(wa.size()), 32'd0);

    // Random gaps with stray start pulses mid-load.
    wa.delete(); wd.delete();
    stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h81, 8'h10, 8'h00, 8'h87};
    pulse_start();
    run_stream(1'b1);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_err", 32'(err), 32'd0);
    chk("t5_cpurst", 32'(cpu_reset), 32'd0);
    chk_two_writes("t5");

    // Reset after the sixth payload byte, then a clean reload.
    wa.delete(); wd.delete();
    stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h81};
    pulse_start();
    run_stream(1'b0);
    chk("t6_partial_nwr", 32'(wa.size()), 32'd1);
    reset = 1'b1;
    #1;
    chk_reset_values("t6_rst");
    tick();
    tick();
    chk("t6_nwr_in_rst", 32'(wa.size()), 32'd1);
    reset = 1'b0;
    tick();
    wa.delete(); wd.delete();
    stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h81, 8'h10, 8'h00, 8'h87};
    pulse_start();
    run_stream(1'b0);
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_cpurst", 32'(cpu_reset), 32'd0);
    chk_two_writes("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
